projectile_motion_ctrl: RTL and testbench
=========================================

// Module: projectile_motion_ctrl
// PURPOSE
//  Upstream stage of the projectile renderer: owns one projectile's life cycle and supplies its
//  top-left position and active flag to the drawing object each frame.
//  Accepts a fire request, spawns the shot at the shooter, and advances it once per frame.
//  Kills the shot on collision or when it leaves the screen, then enforces a reload cooldown.
//  One instance serves the player cannon (UP) and one serves each alien shooter (DOWN).
// PARAMETERS
//  DIR_UP          1     1 = moves toward y=0 (player shot); 0 = moves toward the bottom (alien shot)
//  SPEED           4     pixels moved per frame tick, 1..31
//  SPAWN_OFFSET_X  14    added to shooter_x to centre the shot on the shooter
//  SPAWN_OFFSET_Y  32    UP: spawn y = shooter_y - value; DOWN: spawn y = shooter_y + value
//  PROJ_HEIGHT     32    projectile height in pixels; used for the off-screen test
//  SCREEN_H        480   visible screen height in pixels
//  COOLDOWN_FRAMES 8     frame ticks spent in COOLDOWN before re-arm, 0..255
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  startOfFrame   in   1   one-cycle pulse per VGA frame; motion tick
//  fire_req       in   1   level or pulse; request to launch
//  shooter_x      in   11  signed; shooter top-left x
//  shooter_y      in   11  signed; shooter top-left y
//  collision      in   1   one-cycle pulse from the collision detector: shot hit something
//  proj_x         out  11  signed; projectile top-left x
//  proj_y         out  11  signed; projectile top-left y
//  active         out  1   projectile visible and live
//  fire_ack       out  1   one-cycle pulse: launch accepted
//  shot_done      out  1   one-cycle pulse: flight ended (hit or exit)
// BEHAVIOUR
//  - Reset, asynchronous, any state: state=IDLE; proj_x=0, proj_y=0, active=0, fire_ack=0,
//    shot_done=0, cooldown counter=0. Reset mid-flight aborts the shot with no shot_done.
//  - States: IDLE, FLYING, COOLDOWN.
//  - IDLE: on fire_req=1, the next edge sets FLYING, active=1, fire_ack=1 for one cycle,
//    proj_x=shooter_x+SPAWN_OFFSET_X, proj_y=shooter_y-/+SPAWN_OFFSET_Y (UP/DOWN).
//    This launch takes priority over a coincident startOfFrame: no move in the launch cycle.
//  - FLYING: on startOfFrame, proj_y -= SPEED (UP) or += SPEED (DOWN); proj_x is held.
//  - Exit test uses the post-move y:
//    - UP: exit when y+PROJ_HEIGHT <= 0.
//    - DOWN: exit when y >= SCREEN_H.
//    - On exit, the same edge sets active=0, shot_done=1, and state goes to COOLDOWN.
//  - collision=1 while FLYING: next edge sets active=0, shot_done=1, COOLDOWN. Collision
//    beats a same-cycle move or exit, and shot_done pulses exactly once.
//  - Position on kill: proj_x/proj_y freeze at their last value.
//  - COOLDOWN: the counter loads COOLDOWN_FRAMES on entry and decrements on each startOfFrame.
//    When the counter is 0, the next edge returns to IDLE. With COOLDOWN_FRAMES=0, COOLDOWN
//    lasts exactly one cycle.
//  - Ignored inputs: fire_req outside IDLE is dropped, not queued. collision outside FLYING
//    is ignored.
//  - Arithmetic: all position math is signed, with 12-bit intermediates to avoid wrap.
//    proj_y may go negative, since the renderer handles partial off-screen objects.
//  - Output timing: all outputs are registered. active changes one cycle after its cause.
// STRUCTURE
//  - Shared package space_inv_pkg holds:
//    - typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} proj_state_t;
//    - SCREEN_W=640, SCREEN_H=480 constants;
//    - typedef logic signed [10:0] coord_t.
//  - One sub-module, frame_tick_counter: an 8-bit down-counter with load, decrement on tick,
//    and zero flag. It is reused for alien-fire pacing.
//  - Single always_ff for the FSM and registers, plus an always_comb next-state block.
// TESTING
//  - Launch UP: shooter=(300,440), fire_req pulse.
//    -> next cycle: active=1, proj=(314,408), fire_ack=1 for 1 cycle.
//  - Flight UP: after launch, 3 startOfFrame ticks -> proj_y=404,400,396; proj_x stays 314.
//    No change between ticks.
//  - Exit UP: proj_y=-24, SPEED=4, tick -> y=-28 (still active). Next tick -> y=-32:
//    active=0 and shot_done=1 on the same edge, state COOLDOWN.
//  - Collision with simultaneous tick: proj_y=200, collision=1 and startOfFrame=1 in the same cycle.
//    -> active=0, proj_y stays 200, shot_done exactly 1 pulse.
//  - Cooldown/refire:
//    - fire_req held high through COOLDOWN_FRAMES=8: no fire_ack until 8 ticks have elapsed.
//    - Relaunch happens on the first cycle back in IDLE.
//    - fire_req held high during FLYING is never acked.
//  - Reset: assert reset mid-flight at proj_y=150, no clock edge.
//    -> active=0, proj=(0,0) immediately, no shot_done.
//    - After release, fire_req relaunches normally.

Source files
------------

// File: rtl/space_inv_pkg.sv
// Shared types and screen constants for the space-invaders display pipeline.
package space_inv_pkg;
    typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} proj_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic signed [10:0] coord_t;
endpackage

// File: rtl/frame_tick_counter.sv
// 8-bit frame-tick down-counter: load wins over tick, holds at zero.
module frame_tick_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic       zero
);
    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= 8'd0;
        else if (load)
            count <= load_val;
        else if (tick && count != 8'd0)
            count <= count - 8'd1;
    end

    assign zero = (count == 8'd0);
endmodule

// File: rtl/projectile_motion_ctrl.sv
// Single-projectile life cycle: launch at the shooter, move once per frame,
// kill on hit or screen exit, then hold off re-arming for a frame cooldown.
module projectile_motion_ctrl
    import space_inv_pkg::*;
#(
    parameter bit DIR_UP          = 1'b1,
    parameter int SPEED           = 4,
    parameter int SPAWN_OFFSET_X  = 14,
    parameter int SPAWN_OFFSET_Y  = 32,
    parameter int PROJ_HEIGHT     = 32,
    parameter int SCREEN_H        = 480,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   startOfFrame,
    input  logic   fire_req,
    input  coord_t shooter_x,
    input  coord_t shooter_y,
    input  logic   collision,
    output coord_t proj_x,
    output coord_t proj_y,
    output logic   active,
    output logic   fire_ack,
    output logic   shot_done
);
    localparam logic signed [11:0] SPEED_S  = 12'(SPEED);
    localparam logic signed [11:0] HEIGHT_S = 12'(PROJ_HEIGHT);
    localparam logic signed [11:0] SCR_H_S  = 12'(SCREEN_H);
    localparam coord_t             OFF_X    = 11'(SPAWN_OFFSET_X);
    localparam coord_t             OFF_Y    = 11'(SPAWN_OFFSET_Y);

    proj_state_t state, state_nxt;
    coord_t      x_nxt, y_nxt;
    logic        active_nxt, ack_nxt, done_nxt;
    logic        cd_load, cd_zero;

    // 12-bit move so the exit compare never sees a wrapped coordinate
    logic signed [11:0] y_ext, y_moved;
    logic               exit_hit;
    assign y_ext    = {proj_y[10], proj_y};
    assign y_moved  = DIR_UP ? (y_ext - SPEED_S) : (y_ext + SPEED_S);
    assign exit_hit = DIR_UP ? ((y_moved + HEIGHT_S) <= 12'sd0) : (y_moved >= SCR_H_S);

    frame_tick_counter u_cooldown (
        .clk      (clk),
        .reset    (reset),
        .load     (cd_load),
        .load_val (8'(COOLDOWN_FRAMES)),
        .tick     (startOfFrame && state == COOLDOWN),
        .zero     (cd_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            proj_x    <= '0;
            proj_y    <= '0;
            active    <= 1'b0;
            fire_ack  <= 1'b0;
            shot_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            proj_x    <= x_nxt;
            proj_y    <= y_nxt;
            active    <= active_nxt;
            fire_ack  <= ack_nxt;
            shot_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (fire_req) state_nxt = FLYING;
            FLYING:   if (collision || (startOfFrame && exit_hit)) state_nxt = COOLDOWN;
            COOLDOWN: if (cd_zero) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Collision is checked before the frame move so a hit freezes the position
    always_comb begin
        x_nxt      = proj_x;
        y_nxt      = proj_y;
        active_nxt = active;
        ack_nxt    = 1'b0;
        done_nxt   = 1'b0;
        cd_load    = 1'b0;
        case (state)
            IDLE: if (fire_req) begin
                x_nxt      = shooter_x + OFF_X;
                y_nxt      = DIR_UP ? (shooter_y - OFF_Y) : (shooter_y + OFF_Y);
                active_nxt = 1'b1;
                ack_nxt    = 1'b1;
            end
            FLYING: begin
                if (collision) begin
                    active_nxt = 1'b0;
                    done_nxt   = 1'b1;
                    cd_load    = 1'b1;
                end else if (startOfFrame) begin
                    y_nxt = y_moved[10:0];
                    if (exit_hit) begin
                        active_nxt = 1'b0;
                        done_nxt   = 1'b1;
                        cd_load    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_projectile_motion_ctrl.sv
// Directed bench: an UP shooter with 8-frame cooldown and a DOWN shooter with none.
module tb_projectile_motion_ctrl;
    import space_inv_pkg::*;

    logic   clk = 1'b0, reset = 1'b1, sof = 1'b0;
    logic   fire = 1'b0, col = 1'b0, fire_dn = 1'b0, col_dn = 1'b0;
    coord_t sx = '0, sy = '0, sx_dn = '0, sy_dn = '0;
    coord_t px, py, px_dn, py_dn;
    logic   act, ack, done, act_dn, ack_dn, done_dn;
    int     errors = 0, checks = 0;
    int     cnt;

    always #5 clk = ~clk;

    projectile_motion_ctrl #(.DIR_UP(1'b1), .COOLDOWN_FRAMES(8)) u_up (
        .clk(clk), .reset(reset), .startOfFrame(sof), .fire_req(fire),
        .shooter_x(sx), .shooter_y(sy), .collision(col),
        .proj_x(px), .proj_y(py), .active(act), .fire_ack(ack), .shot_done(done)
    );

    projectile_motion_ctrl #(.DIR_UP(1'b0), .COOLDOWN_FRAMES(0)) u_dn (
        .clk(clk), .reset(reset), .startOfFrame(sof), .fire_req(fire_dn),
        .shooter_x(sx_dn), .shooter_y(sy_dn), .collision(col_dn),
        .proj_x(px_dn), .proj_y(py_dn), .active(act_dn), .fire_ack(ack_dn), .shot_done(done_dn)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sof = 1'b1;
        step();
        sof = 1'b0;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_x", px, 0); chk("rst_y", py, 0); chk("rst_act", act, 0);
        chk("rst_ack", ack, 0); chk("rst_done", done, 0);
        reset = 1'b0;
        step();

        // launch UP
        sx = 11'sd300; sy = 11'sd440; fire = 1'b1;
        step();
        fire = 1'b0;
        chk("launch_act", act, 1); chk("launch_x", px, 314); chk("launch_y", py, 408);
        chk("launch_ack", ack, 1);
        step();
        chk("ack_one_cycle", ack, 0); chk("hold_y", py, 408);

        // flight with fire held: never acked
        fire = 1'b1;
        tick(); chk("fly_y1", py, 404); step(); chk("fly_hold1", py, 404);
        tick(); chk("fly_y2", py, 400); step(); chk("fly_hold2", py, 400);
        tick(); chk("fly_y3", py, 396); chk("fly_x", px, 314);
        cnt = 0;
        for (int i = 0; i < 105; i++) begin
            tick();
            if (ack) cnt++;
        end
        chk("fly_no_ack", cnt, 0);
        chk("pre_exit_y", py, -24); chk("pre_exit_act", act, 1);

        // exit UP
        tick(); chk("exit_y28", py, -28); chk("exit_act28", act, 1); chk("exit_done28", done, 0);
        tick(); chk("exit_y32", py, -32); chk("exit_act32", act, 0); chk("exit_done32", done, 1);
        step(); chk("exit_done_pulse", done, 0);

        // cooldown with fire held high
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack || act) cnt++;
        end
        chk("cd_no_ack", cnt, 0);
        step(); chk("cd_idle_no_ack", ack, 0);
        step(); chk("refire_ack", ack, 1); chk("refire_act", act, 1); chk("refire_y", py, 408);
        fire = 1'b0;

        // collision coincident with a frame tick
        for (int i = 0; i < 52; i++) tick();
        chk("pre_col_y", py, 200);
        col = 1'b1; sof = 1'b1;
        step();
        col = 1'b0; sof = 1'b0;
        chk("col_act", act, 0); chk("col_y", py, 200); chk("col_done", done, 1);
        step(); chk("col_done_once", done, 0); chk("col_x", px, 314);
        col = 1'b1;
        step();
        col = 1'b0;
        chk("col_ignored_done", done, 0); chk("col_ignored_act", act, 0);

        // wait out cooldown, launch, then async reset mid-flight
        for (int i = 0; i < 8; i++) tick();
        step();
        sy = 11'sd186; fire = 1'b1;
        step();
        fire = 1'b0;
        chk("relaunch_y", py, 154); chk("relaunch_ack", ack, 1);
        tick(); chk("mid_y", py, 150);
        #2 reset = 1'b1;
        #1;
        chk("arst_act", act, 0); chk("arst_x", px, 0); chk("arst_y", py, 0); chk("arst_done", done, 0);
        step();
        reset = 1'b0;
        fire = 1'b1;
        step();
        fire = 1'b0;
        chk("post_rst_ack", ack, 1); chk("post_rst_y", py, 154); chk("post_rst_x", px, 314);

        // DOWN shooter, zero-frame cooldown
        sx_dn = 11'sd100; sy_dn = 11'sd400; fire_dn = 1'b1;
        step();
        chk("dn_launch_x", px_dn, 114); chk("dn_launch_y", py_dn, 432); chk("dn_ack", ack_dn, 1);
        cnt = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (ack_dn) cnt++;
        end
        chk("dn_no_ack", cnt, 0); chk("dn_y476", py_dn, 476); chk("dn_act476", act_dn, 1);
        tick(); chk("dn_y480", py_dn, 480); chk("dn_act480", act_dn, 0); chk("dn_done", done_dn, 1);
        step(); chk("dn_cd_ack", ack_dn, 0); chk("dn_done_pulse", done_dn, 0);
        step(); chk("dn_refire_ack", ack_dn, 1); chk("dn_refire_y", py_dn, 432);
        fire_dn = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
